mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Load/store stage directly downstream of the ALU in the NaiveCPU datapath.
- Takes the ALU result as the effective address and the rs2 value as store data.
- Performs RISC-V byte/half/word accesses over a word-wide data-memory/MMIO bus that may insert wait states.
- Stalls the single-cycle core until each access completes, then returns the sign- or zero-extended load value to writeback.

Parameters:
TIMEOUT, 255, max ACCESS-state cycles waiting for bus_ready before aborting with a fault (1..65535).

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset (sampled on rising edge of clk)
mem_read  input  1  current instruction is a load
mem_write  input  1  current instruction is a store
funct3  input  3  access size/sign: LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101
addr  input  32  effective byte address (ALU result)
write_data  input  32  store data (rs2)
stall  output  1  holds PC/instruction while an access is pending
load_data  output  32  extended load result, valid while in DONE
fault  output  1  misaligned, illegal-encoding or timed-out access
bus_req  output  1  bus request, held until bus_ready
bus_we  output  1  1 = write
bus_addr  output  32  word address ({addr[31:2],2'b00})
bus_be  output  4  byte enables
bus_wdata  output  32  lane-aligned store data
bus_ready  input  1  bus completes access this cycle
bus_rdata  input  32  read word, valid when bus_ready=1

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE; bus_req, bus_we, bus_be, bus_addr, bus_wdata, load_data, fault = 0; timeout counter = 0. While rst_n=0, stall is forced to 0.
- Reset mid-access abandons the transfer. bus_req is low from the next cycle. Late bus_ready is ignored.
- Check (combinational, IDLE only). A request is mem_read^mem_write.
  - Illegal if any of:
    - mem_read and mem_write both 1
    - load funct3 is 011, 110 or 111
    - store funct3 >= 011
    - LH/LHU/SH with addr[0]=1
    - LW/SW with addr[1:0]!=0
  - Illegal requests go IDLE->DONE with fault=1 and no bus activity.
- FSM states IDLE, ACCESS, DONE.
  - IDLE, legal request: latch addr[1:0], funct3, we; drive bus_addr/bus_be/bus_wdata/bus_we; assert bus_req; go to ACCESS; clear counter.
  - IDLE, no request: stay.
  - ACCESS, bus_ready=1: capture bus_rdata (loads); drop bus_req and bus_be; go to DONE with fault=0.
  - ACCESS, bus_ready=0: increment counter. When counter reaches TIMEOUT-1 without ready: drop bus_req, go to DONE with fault=1, load_data=0.
  - DONE: always go to IDLE next cycle.
- stall = request present && state!=DONE (combinational).
  - A legal access therefore stalls for 2 + wait cycles. It stalls exactly 2 cycles when bus_ready is high in the first ACCESS cycle.
  - stall is low in DONE, so the core retires the instruction on the DONE edge.
  - A back-to-back memory instruction starts in the following IDLE cycle.
- Bus outputs are registered and stable throughout ACCESS. bus_ready in IDLE or DONE is ignored.
- Byte lanes, with o=addr[1:0]:
  - SB: bus_be = 0001<<o; bus_wdata = byte replicated ×4.
  - SH: bus_be = 0011<<(2*o[1]); bus_wdata = half replicated ×2.
  - SW: bus_be = 1111; bus_wdata = write_data.
  - Loads: bus_be = 1111.
- Load extraction is applied to the captured word, registered into load_data on the ACCESS->DONE edge:
  - LB/LBU: byte o, sign-/zero-extended.
  - LH/LHU: half o[1], sign-/zero-extended.
  - LW: whole word.
- Stores leave load_data = 0.
- fault and load_data are meaningful only in DONE and clear to 0 on the DONE->IDLE edge.

Test Plan:
- Reset, then LW addr=0x10, bus_ready on first ACCESS cycle with rdata=0xDEADBEEF -> bus_addr=0x10, be=1111; stall high exactly 2 cycles; DONE load_data=0xDEADBEEF, fault=0.
- LB addr=0x13, rdata=0x80FF0011 -> load_data=0xFFFFFF80. LBU at the same addr -> 0x00000080. LHU addr=0x12 -> 0x000080FF.
- SB addr=0x21, write_data=0x000000A5 -> bus_we=1, be=0010, wdata=0xA5A5A5A5. SH addr=0x22, write_data=0x1234 -> be=1100, wdata=0x12341234.
- LW addr=0x02 -> no bus_req ever; next cycle DONE with fault=1, stall low. Same outcome with mem_read=mem_write=1.
- TIMEOUT=4, bus_ready held 0 -> bus_req high 4 cycles then low; DONE with fault=1, load_data=0; then IDLE.
- Assert rst_n=0 in the 3rd ACCESS wait cycle -> next cycle IDLE, bus_req=0, stall=0. bus_ready=1 arriving after release produces no DONE.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Word-wide data-memory/MMIO bus between the load/store unit and memory.
// master: request side (req/we/addr/be/wdata out, ready/rdata in); slave: memory side.
interface mem_access_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req,
    output bus_we,
    output bus_addr,
    output bus_be,
    output bus_wdata,
    input  bus_ready,
    input  bus_rdata
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_addr,
    input  bus_be,
    input  bus_wdata,
    output bus_ready,
    output bus_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store stage: byte/half/word accesses over a wait-state bus.
// Ports: clk, rst_n, mem_read/mem_write/funct3/addr/write_data in; stall/load_data/fault out; bus (master).
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       write_data,
  output logic              stall,
  output logic [31:0]       load_data,
  output logic              fault,
  mem_access_unit_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic [15:0] cnt;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic        we_q;

  logic        req;
  logic        illegal;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [7:0]  rb;
  logic [15:0] rh;
  logic [31:0] ext;

  assign req = mem_read ^ mem_write;

  assign stall = rst_n & req & (state != S_DONE);

  always_comb begin
    illegal = 1'b0;
    if (mem_read && mem_write) begin
      illegal = 1'b1;
    end else if (mem_read) begin
      illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
    end else if (mem_write) begin
      illegal = (funct3 >= 3'b011);
    end
    if (req && funct3[1:0] == 2'b01 && addr[0])
      illegal = 1'b1;
    if (req && funct3 == 3'b010 && addr[1:0] != 2'b00)
      illegal = 1'b1;
  end

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = write_data;
    unique case (1'b1)
      funct3[1:0] == 2'b00: begin
        st_be    = 4'b0001 << addr[1:0];
        st_wdata = {4{write_data[7:0]}};
      end
      funct3[1:0] == 2'b01: begin
        st_be    = addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{write_data[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = write_data;
      end
    endcase
  end

  // Extraction works on the raw bus word in the completing cycle
  always_comb begin
    rb  = bus.bus_rdata[{off_q, 3'b000} +: 8];
    rh  = off_q[1] ? bus.bus_rdata[31:16]
                   : bus.bus_rdata[15:0];
    ext = bus.bus_rdata;
    unique case (f3_q)
      3'b000:  ext = {{24{rb[7]}}, rb};
      3'b100:  ext = {24'd0, rb};
      3'b001:  ext = {{16{rh[15]}}, rh};
      3'b101:  ext = {16'd0, rh};
      default: ext = bus.bus_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      off_q         <= '0;
      f3_q          <= '0;
      we_q          <= 1'b0;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_be    <= '0;
      bus.bus_wdata <= '0;
      load_data     <= '0;
      fault         <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          fault     <= 1'b0;
          load_data <= '0;
          if (illegal) begin
            fault <= 1'b1;
            state <= S_DONE;
          end else if (req) begin
            off_q         <= addr[1:0];
            f3_q          <= funct3;
            we_q          <= mem_write;
            bus.bus_req   <= 1'b1;
            bus.bus_we    <= mem_write;
            bus.bus_addr  <= {addr[31:2], 2'b00};
            bus.bus_be    <= mem_write ? st_be : 4'b1111;
            bus.bus_wdata <= mem_write ? st_wdata : '0;
            cnt           <= '0;
            state         <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (bus.bus_ready) begin
            bus.bus_req <= 1'b0;
            bus.bus_be  <= '0;
            load_data   <= we_q ? '0 : ext;
            fault       <= 1'b0;
            state       <= S_DONE;
          end else if (cnt == TO_LAST) begin
            bus.bus_req <= 1'b0;
            bus.bus_be  <= '0;
            load_data   <= '0;
            fault       <= 1'b1;
            state       <= S_DONE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_DONE: begin
          fault     <= 1'b0;
          load_data <= '0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed plan steps then random accesses
// checked against a byte-lane reference model.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        stall;
  logic [31:0] load_data;
  logic        fault;

  int checks = 0;
  int passes = 0;

  mem_access_unit_if bus ();

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .addr       (addr),
    .write_data (write_data),
    .stall      (stall),
    .load_data  (load_data),
    .fault      (fault),
    .bus        (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic void model(
    input  logic        rd,
    input  logic        wr,
    input  logic [2:0]  f3,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    input  logic [31:0] word,
    output bit          legal,
    output logic [3:0]  be,
    output logic [31:0] wdat,
    output logic [31:0] ld
  );
    int o;
    int size;
    logic [31:0] v;
    logic [31:0] m;
    o     = int'(a[1:0]);
    size  = 1;
    legal = 1;
    be    = '0;
    wdat  = '0;
    ld    = '0;
    if (rd && wr) legal = 0;
    else begin
      case (f3)
        3'd0:    size = 1;
        3'd1:    size = 2;
        3'd2:    size = 4;
        3'd4:    begin size = 1; legal = rd; end
        3'd5:    begin size = 2; legal = rd; end
        default: legal = 0;
      endcase
    end
    if (legal && (o % size) != 0) legal = 0;
    if (legal && rd) begin
      be = 4'hF;
      v  = word >> (8 * o);
      if (size < 4) begin
        m = (32'd1 << (8 * size)) - 32'd1;
        v = v & m;
        if (!f3[2] && v[8*size-1]) v = v | ~m;
      end
      ld = v;
    end
    if (legal && wr) begin
      be = 4'(((1 << size) - 1) << o);
      for (int i = 0; i < 4; i++)
        wdat[8*i +: 8] = wd[8*(i % size) +: 8];
    end
  endfunction

  task automatic access(input logic rd, input logic wr,
                        input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] word,
                        input int waits);
    bit          legal;
    bit          done;
    bit          tmo;
    int          n;
    logic [3:0]  be;
    logic [31:0] wdat;
    logic [31:0] ld;
    model(rd, wr, f3, a, wd, word, legal, be, wdat, ld);
    @(negedge clk);
    chk("idle_fault", fault, 0);
    chk("idle_load", load_data, 0);
    mem_read      = rd;
    mem_write     = wr;
    funct3        = f3;
    addr          = a;
    write_data    = wd;
    bus.bus_ready = 1'b0;
    #1;
    chk("idle_stall", stall, rd ^ wr);
    if (!(rd | wr)) begin
      @(negedge clk);
      chk("noreq_busreq", bus.bus_req, 0);
      chk("noreq_stall", stall, 0);
    end else if (!legal) begin
      @(negedge clk);
      chk("ill_fault", fault, 1);
      chk("ill_stall", stall, 0);
      chk("ill_busreq", bus.bus_req, 0);
      chk("ill_load", load_data, 0);
    end else begin
      tmo  = (waits >= TO);
      n    = 0;
      done = 0;
      while (!done && n < 64) begin
        @(negedge clk);
        if (!stall) done = 1;
        else begin
          if (n == 0) begin
            chk("bus_addr", bus.bus_addr, {a[31:2], 2'b00});
            chk("bus_be", bus.bus_be, be);
            chk("bus_we", bus.bus_we, wr);
            if (wr) chk("bus_wdata", bus.bus_wdata, wdat);
          end
          chk("bus_req_held", bus.bus_req, 1);
          bus.bus_ready = (n == waits);
          bus.bus_rdata = (n == waits) ? word : $urandom;
          n++;
        end
      end
      bus.bus_ready = 1'b0;
      chk("done_seen", done, 1);
      chk("access_cycles", n, tmo ? TO : waits + 1);
      chk("done_fault", fault, tmo);
      chk("done_load", load_data, tmo ? 32'd0 : ld);
      chk("done_busreq", bus.bus_req, 0);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    mem_read      = 1'b1;
    mem_write     = 1'b0;
    funct3        = 3'b010;
    addr          = 32'h10;
    write_data    = '0;
    bus.bus_ready = 1'b0;
    bus.bus_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_stall", stall, 0);
    chk("rst_busreq", bus.bus_req, 0);
    chk("rst_we", bus.bus_we, 0);
    chk("rst_be", bus.bus_be, 0);
    chk("rst_addr", bus.bus_addr, 0);
    chk("rst_wdata", bus.bus_wdata, 0);
    chk("rst_load", load_data, 0);
    chk("rst_fault", fault, 0);
    mem_read = 1'b0;
    rst_n    = 1'b1;

    access(1, 0, 3'b010, 32'h10, 0, 32'hDEADBEEF, 0);
    access(1, 0, 3'b000, 32'h13, 0, 32'h80FF0011, 1);
    access(1, 0, 3'b100, 32'h13, 0, 32'h80FF0011, 0);
    access(1, 0, 3'b101, 32'h12, 0, 32'h80FF0011, 2);
    access(1, 0, 3'b001, 32'h12, 0, 32'h80FF0011, 0);
    access(0, 1, 3'b000, 32'h21, 32'h000000A5, 0, 0);
    access(0, 1, 3'b001, 32'h22, 32'h00001234, 0, 1);
    access(0, 1, 3'b010, 32'h24, 32'hCAFEF00D, 0, 3);
    access(1, 0, 3'b010, 32'h02, 0, 0, 0);
    access(1, 1, 3'b010, 32'h10, 0, 0, 0);
    access(1, 0, 3'b011, 32'h10, 0, 0, 0);
    access(0, 1, 3'b100, 32'h10, 0, 0, 0);
    access(1, 0, 3'b010, 32'h40, 0, 32'h12345678, 10);
    access(0, 0, 3'b010, 32'h40, 0, 0, 0);

    @(negedge clk);
    mem_read      = 1'b1;
    mem_write     = 1'b0;
    funct3        = 3'b010;
    addr          = 32'h80;
    bus.bus_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busreq", bus.bus_req, 1);
    chk("mid_stall", stall, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_busreq", bus.bus_req, 0);
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_fault", fault, 0);
    mem_read      = 1'b0;
    rst_n         = 1'b1;
    bus.bus_ready = 1'b1;
    bus.bus_rdata = 32'hA5A5A5A5;
    repeat (3) begin
      @(negedge clk);
      chk("late_ready_stall", stall, 0);
      chk("late_ready_fault", fault, 0);
      chk("late_ready_load", load_data, 0);
      chk("late_ready_busreq", bus.bus_req, 0);
    end
    bus.bus_ready = 1'b0;

    for (int k = 0; k < 60; k++) begin
      access(1'($urandom), 1'($urandom), 3'($urandom), $urandom,
             $urandom, $urandom, int'($urandom_range(0, 5)));
    end

    @(negedge clk);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
